// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared types and constants for the frequency meter.
// Contents: state_t (IDLE/MEASURE/HOLD), CLK_HZ (nominal clk_in frequency).
package freq_meter_pkg;
    typedef enum logic [1:0] {IDLE, MEASURE, HOLD} state_t;
    localparam int unsigned CLK_HZ = 100000000;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-flop synchronizer plus edge register, emits a 1-cycle rise pulse.
// Ports: clk_in (clock), reset_n (async active-low reset), sig_in (async input),
//        rise (1-cycle pulse per synchronized rising edge).
module sync_edge_detect (
    input  logic clk_in,
    input  logic reset_n,
    input  logic sig_in,
    output logic rise
);
    logic s1, s2, s3;
    logic [2:0] vld;
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            s3  <= 1'b0;
            vld <= '0;
        end else begin
            s1  <= sig_in;
            s2  <= s1;
            s3  <= s2;
            vld <= {vld[1:0], 1'b1};
        end
    end
    // vld masks the pulse until s3 holds a real sample, so a high input at
    // reset release is not mistaken for a 0->1 transition.
    assign rise = vld[2] & s2 & ~s3;
endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts sig_in rising edges over a GATE_CYCLES-long gate, with valid/ready result.
// Ports: clk_in, reset_n (async active-low), sig_in, start, busy,
//        result[CNT_W], result_valid, result_ready, overflow.
// Option: FREQ_METER_CONTINUOUS_EN restarts a gate right after each result handshake.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 100000000,
    parameter int          CNT_W       = 32
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overflow
);
    localparam logic [31:0] GATE_LOAD = 32'(GATE_CYCLES - 1);
    state_t state, state_nxt;
    logic [31:0] gate_cnt;
    logic [CNT_W-1:0] edge_cnt, edge_nxt;
    logic ovf, ovf_nxt, rise, load, done, ack;
    sync_edge_detect u_sync (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .sig_in  (sig_in),
        .rise    (rise)
    );
    always_comb begin
        ack = (state == HOLD) && result_ready;
        done = (state == MEASURE) && (gate_cnt == '0);
`ifdef FREQ_METER_CONTINUOUS_EN
        load = ((state == IDLE) && start) || ack;
`else
        load = (state == IDLE) && start;
`endif
        state_nxt = load ? MEASURE : done ? HOLD : ack ? IDLE : state;
        // Saturating count: once all ones, further edges only raise ovf.
        edge_nxt = (rise && !(&edge_cnt)) ? edge_cnt + CNT_W'(1) : edge_cnt;
        ovf_nxt = ovf | (rise & (&edge_cnt));
    end
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                gate_cnt <= GATE_LOAD;
                edge_cnt <= '0;
                ovf      <= 1'b0;
            end else if (state == MEASURE) begin
                edge_cnt <= edge_nxt;
                ovf      <= ovf_nxt;
                if (done) begin
                    result   <= edge_nxt;
                    overflow <= ovf_nxt;
                end else begin
                    gate_cnt <= gate_cnt - 32'd1;
                end
            end
        end
    end
    assign busy = (state == MEASURE);
    assign result_valid = (state == HOLD);
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed self-checking bench for freq_meter (GATE_CYCLES=100; CNT_W=8 and 4).
module tb_freq_meter;
    logic clk_in = 1'b0;
    logic reset_n = 1'b0;
    logic sig_in = 1'b0;
    logic start = 1'b0;
    logic start4 = 1'b0;
    logic result_ready = 1'b0;
    logic result_ready4 = 1'b0;
    logic busy, result_valid, overflow;
    logic busy4, result_valid4, overflow4;
    logic [7:0] result;
    logic [3:0] result4;
    logic lvl = 1'b0;
    int per = 0;
    int ph = 0;
    int checks = 0;
    int errors = 0;
    int n;

    freq_meter #(.GATE_CYCLES(100), .CNT_W(8)) dut (
        .clk_in       (clk_in),
        .reset_n      (reset_n),
        .sig_in       (sig_in),
        .start        (start),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overflow     (overflow)
    );

    freq_meter #(.GATE_CYCLES(100), .CNT_W(4)) dut4 (
        .clk_in       (clk_in),
        .reset_n      (reset_n),
        .sig_in       (sig_in),
        .start        (start4),
        .busy         (busy4),
        .result       (result4),
        .result_valid (result_valid4),
        .result_ready (result_ready4),
        .overflow     (overflow4)
    );

    always #5 clk_in = ~clk_in;

    // Periodic stimulus (per>0, 50% duty) or constant level lvl (per==0).
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            ph++;
            sig_in = (per == 0) ? lvl : ((ph % per) < (per / 2));
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        reset_n = 1'b0;
        start = 1'b0;
        start4 = 1'b0;
        result_ready = 1'b0;
        result_ready4 = 1'b0;
        repeat (3) @(negedge clk_in);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_in);
    endtask

    // Pulse start, then count cycles busy stays high (bounded).
    task automatic gate8(output int cnt);
        @(negedge clk_in);
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        cnt = 0;
        while (busy && cnt < 1000) begin
            cnt++;
            @(negedge clk_in);
        end
    endtask

    task automatic handshake8();
        @(negedge clk_in);
        result_ready = 1'b1;
        @(negedge clk_in);
        result_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk_in);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(result_valid), 0);
        check("rst_result", 32'(result), 0);
        check("rst_ovf", 32'(overflow), 0);
        reset_n = 1'b1;

        // 10-cycle period -> 10 edges in 100-cycle gate
        per = 10;
        do_reset();
        gate8(n);
        check("t1_busy_len", n, 100);
        check("t1_valid", 32'(result_valid), 1);
        check("t1_result", 32'(result), 10);
        check("t1_ovf", 32'(overflow), 0);
        repeat (5) @(negedge clk_in);
        check("t1_valid_hold", 32'(result_valid), 1);
        check("t1_result_hold", 32'(result), 10);
        handshake8();
        check("t1_valid_drop", 32'(result_valid), 0);
        check("t1_result_kept", 32'(result), 10);
`ifdef FREQ_METER_CONTINUOUS_EN
        check("t1_busy_after", 32'(busy), 1);
`else
        check("t1_busy_after", 32'(busy), 0);
`endif

        // Constant high across reset release, start right at release -> 0
        per = 0;
        lvl = 1'b1;
        @(negedge clk_in);
        reset_n = 1'b0;
        repeat (3) @(negedge clk_in);
        reset_n = 1'b1;
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        n = 0;
        while (busy && n < 1000) begin
            n++;
            @(negedge clk_in);
        end
        check("t2_busy_len", n, 100);
        check("t2_result", 32'(result), 0);
        check("t2_ovf", 32'(overflow), 0);

        // CNT_W=4, 2-cycle period -> 50 edges saturate at 15
        lvl = 1'b0;
        per = 2;
        do_reset();
        @(negedge clk_in);
        start4 = 1'b1;
        @(negedge clk_in);
        start4 = 1'b0;
        n = 0;
        while (busy4 && n < 1000) begin
            n++;
            @(negedge clk_in);
        end
        check("t3_busy_len", n, 100);
        check("t3_valid", 32'(result_valid4), 1);
        check("t3_result", 32'(result4), 15);
        check("t3_ovf", 32'(overflow4), 1);
        check("t3_other_idle", 32'(result_valid), 0);

        // start pulses during MEASURE and HOLD are ignored
        per = 10;
        do_reset();
        @(negedge clk_in);
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        n = 0;
        while (busy && n < 1000) begin
            start = (n == 30);
            n++;
            @(negedge clk_in);
        end
        start = 1'b0;
        check("t4_busy_len", n, 100);
        check("t4_result", 32'(result), 10);
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        check("t4_hold_busy", 32'(busy), 0);
        check("t4_hold_valid", 32'(result_valid), 1);
        start = 1'b1;
        result_ready = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        result_ready = 1'b0;
        check("t4_ack_valid", 32'(result_valid), 0);
`ifdef FREQ_METER_CONTINUOUS_EN
        check("t4_ack_busy", 32'(busy), 1);
`else
        check("t4_ack_busy", 32'(busy), 0);
`endif

        // Reset at gate cycle 50 aborts; new run gives 10
        do_reset();
        @(negedge clk_in);
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        repeat (50) @(negedge clk_in);
        reset_n = 1'b0;
        #1;
        check("t5_abort_busy", 32'(busy), 0);
        check("t5_abort_result", 32'(result), 0);
        repeat (3) @(negedge clk_in);
        reset_n = 1'b1;
        n = 0;
        repeat (150) begin
            @(negedge clk_in);
            if (result_valid) n++;
        end
        check("t5_no_valid", n, 0);
        gate8(n);
        check("t5_busy_len", n, 100);
        check("t5_result", 32'(result), 10);

        // result held while ready stays low for 300 cycles
        per = 5;
        n = 0;
        repeat (300) begin
            @(negedge clk_in);
            if (!result_valid || result != 8'd10) n++;
        end
        check("t6_hold_stable", n, 0);
        handshake8();
        check("t6_valid_drop", 32'(result_valid), 0);
`ifdef FREQ_METER_CONTINUOUS_EN
        check("t6_restart", 32'(busy), 1);
`else
        check("t6_restart", 32'(busy), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 100000000, is the measurement gate length in clk_in cycles (1 s at 100 MHz); legal range 2..2^32-1.
REQ-002 Parameter CNT_W, default 32, is the width of the edge counter and of result.
REQ-003 clk_in  input  1  single 100 MHz system clock; all logic is on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 sig_in  input  1  signal under measurement, asynchronous to clk_in.
REQ-006 start  input  1  one-cycle request to begin a measurement.
REQ-007 busy  output  1  high from the accepted start until result_valid rises.
REQ-008 result  output  CNT_W  number of sig_in rising edges counted in the last gate.
REQ-009 result_valid  output  1  result is held stable while this is high.
REQ-010 result_ready  input  1  consumer acknowledge; a transfer occurs when result_valid and result_ready are both high.
REQ-011 overflow  output  1  the last gate saturated the counter; valid with result_valid.

Function
REQ-012 FSM states: IDLE, MEASURE, HOLD.
REQ-013 IDLE->MEASURE on start=1; busy rises the next cycle, the edge counter clears to 0, and the gate counter loads GATE_CYCLES-1.
REQ-014 sig_in passes a 2-flop synchronizer followed by an edge register; a rising edge is flagged 3 clk_in cycles after the sig_in transition.
REQ-015 In MEASURE, each flagged edge increments the edge counter; the gate counter decrements once per cycle.
REQ-016 The gate is exactly GATE_CYCLES cycles; an edge flagged in the last gate cycle is counted.
REQ-017 When the gate counter reaches 0, the block goes MEASURE->HOLD; result and overflow are registered the same cycle, then result_valid=1 and busy=0 from the next cycle.
REQ-018 The edge counter saturates at 2^CNT_W-1 and sets overflow; it does not wrap.
REQ-019 HOLD->IDLE on the cycle result_valid&&result_ready; result_valid drops the next cycle, and result and overflow keep their last value.
REQ-020 start is ignored in MEASURE and HOLD; it is neither queued nor restarting.
REQ-021 result_ready is ignored when result_valid=0.
REQ-022 If start and result_ready arrive in the same HOLD cycle, only the handshake completes; start is dropped.

Reset
REQ-023 On reset_n=0, the state is IDLE and busy=0, result_valid=0, overflow=0, result=0, all counters=0, and the synchronizer flops=0.
REQ-024 Reset asserted mid-measurement aborts the measurement and discards the partial count; no result_valid is produced.
REQ-025 After reset release, the first sig_in edge can be flagged no earlier than 3 cycles later, and no spurious edge is flagged from the reset value.

Configuration
REQ-026 Macro FREQ_METER_CONTINUOUS_EN:
- Defined: in HOLD, the block also re-enters MEASURE the cycle after the handshake without needing start, and busy rises with it.
- Defined: if result_valid is still high when the next gate would start, the block waits in HOLD and does not overwrite result.
- Undefined: behaviour is exactly REQ-013..REQ-022.

Structure
REQ-027 Package freq_meter_pkg holds the FSM state enum (IDLE/MEASURE/HOLD) and the constant CLK_HZ=100000000.
REQ-028 One sub-module, sync_edge_detect, contains the 2-flop synchronizer and the edge register; it outputs a 1-cycle rise pulse.

Verification (GATE_CYCLES=100, CNT_W=8)
REQ-029 sig_in periodic with a 10-cycle period, start pulse -> busy for 100 cycles, then result=10, overflow=0, result_valid=1 until result_ready.
REQ-030 sig_in held constant 1, start -> result=0.
REQ-031 CNT_W=4, sig_in with a 2-cycle period -> result=15, overflow=1.
REQ-032 start pulses during MEASURE and HOLD -> no restart; result identical to REQ-029.
REQ-033 reset_n low at gate cycle 50, then start after release -> no result_valid for the aborted run; the new run gives result=10.
REQ-034 With FREQ_METER_CONTINUOUS_EN defined and result_ready held low for 300 cycles -> result_valid stays high, result is unchanged, and a new gate starts the cycle after ready.
